// File: rtl/mux2_arb_pkg.sv
// Shared types and constants for the two-requester round-robin select arbiter.
// The state encoding is exported here so debug ports and checkers can decode it.
package mux2_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_A = 2'd1,
        GNT_B = 2'd2
    } state_t;

    localparam logic SEL_A = 1'b1;
    localparam logic SEL_B = 1'b0;
    localparam int   HOLD_W = 8;

endpackage

// File: rtl/mux2_hold_timer.sv
// Saturating tenure counter; expired flags that the current holder has used its
// full allowance and must yield if the other side is waiting.
module mux2_hold_timer
    import mux2_arb_pkg::*;
#(
    parameter int MAX_HOLD = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic expired
);

    localparam logic [HOLD_W-1:0] LIMIT = HOLD_W'(MAX_HOLD - 1);

    logic [HOLD_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if (en && (cnt != LIMIT)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expired = (cnt == LIMIT);

endmodule

// File: rtl/mux2_rr_arbiter.sv
// Round-robin arbiter for a shared 2:1 select lane with a bounded tenure.
// Grants and select are registered; y is a pure combinational mux on sel.
module mux2_rr_arbiter
    import mux2_arb_pkg::*;
#(
    parameter int W        = 1,
    parameter int MAX_HOLD = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_a,
    input  logic         req_b,
    input  logic [W-1:0] data_a,
    input  logic [W-1:0] data_b,
    output logic         gnt_a,
    output logic         gnt_b,
    output logic         sel,
    output logic [W-1:0] y,
    output logic         valid,
    output state_t       dbg_state
);

    // Handshake: req_* is a level held for the whole transfer; gnt_* rises one
    // cycle after req is sampled high and falls one cycle after req drops. A
    // requester must ignore the single trailing grant cycle after its release.

    state_t state, state_next;
    logic   last_sel;
    logic   expired;
    logic   timer_clear;
    logic   gnt_a_d, gnt_b_d, sel_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            last_sel <= SEL_B;
            gnt_a    <= 1'b0;
            gnt_b    <= 1'b0;
            sel      <= SEL_B;
        end else begin
            state <= state_next;
            gnt_a <= gnt_a_d;
            gnt_b <= gnt_b_d;
            sel   <= sel_d;
            if (state_next != state && state_next != IDLE) begin
                last_sel <= (state_next == GNT_A) ? SEL_A : SEL_B;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (req_a && req_b) begin
                    state_next = (last_sel == SEL_A) ? GNT_B : GNT_A;
                end else if (req_a) begin
                    state_next = GNT_A;
                end else if (req_b) begin
                    state_next = GNT_B;
                end
            end
            GNT_A: begin
                if (!req_a) begin
                    state_next = req_b ? GNT_B : IDLE;
                end else if (req_b && expired) begin
                    state_next = GNT_B;
                end
            end
            GNT_B: begin
                if (!req_b) begin
                    state_next = req_a ? GNT_A : IDLE;
                end else if (req_a && expired) begin
                    state_next = GNT_A;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs are decoded from the next state and captured with it, so grants
    // and select line up exactly with the state register.
    always_comb begin
        gnt_a_d = 1'b0;
        gnt_b_d = 1'b0;
        sel_d   = sel;
        case (state_next)
            GNT_A: begin
                gnt_a_d = 1'b1;
                sel_d   = SEL_A;
            end
            GNT_B: begin
                gnt_b_d = 1'b1;
                sel_d   = SEL_B;
            end
            default: ;
        endcase
    end

    assign timer_clear = (state_next != state) || (state_next == IDLE);

    mux2_hold_timer #(
        .MAX_HOLD(MAX_HOLD)
    ) u_hold_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (timer_clear),
        .en     (!timer_clear),
        .expired(expired)
    );

    assign y         = sel ? data_a : data_b;
    assign valid     = gnt_a | gnt_b;
    assign dbg_state = state;

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Bench for mux2_rr_arbiter: directed vector table, hand-written multi-cycle
// sequences, and randomized traffic checked against a tenure-level model.
module tb_mux2_rr_arbiter;
    import mux2_arb_pkg::*;

    localparam int W        = 4;
    localparam int MAX_HOLD = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req_a = 1'b0;
    logic         req_b = 1'b0;
    logic [W-1:0] data_a = '0;
    logic [W-1:0] data_b = '0;
    logic         gnt_a, gnt_b, sel, valid;
    logic [W-1:0] y;
    state_t       dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    mux2_rr_arbiter #(.W(W), .MAX_HOLD(MAX_HOLD)) dut (
        .clk      (clk),
        .rst      (rst),
        .req_a    (req_a),
        .req_b    (req_b),
        .data_a   (data_a),
        .data_b   (data_b),
        .gnt_a    (gnt_a),
        .gnt_b    (gnt_b),
        .sel      (sel),
        .y        (y),
        .valid    (valid),
        .dbg_state(dbg_state)
    );

    // clock / reset block
    always #5 clk = ~clk;

    // reference model: who owns the lane, how long they have held it, who went last
    int m_own = 0;      // 0 = nobody, 1 = A, 2 = B
    int m_ten = 0;      // cycles granted in the current tenure
    bit m_last_a = 1'b0;
    bit m_sel = 1'b0;

    task automatic model_step(input bit r, input bit ra, input bit rb);
        int nxt;
        bit mine, other;
        if (r) begin
            m_own = 0; m_ten = 0; m_last_a = 1'b0; m_sel = 1'b0;
            return;
        end
        if (m_own == 0) begin
            if (ra && rb) nxt = m_last_a ? 2 : 1;
            else if (ra)  nxt = 1;
            else if (rb)  nxt = 2;
            else          nxt = 0;
        end else begin
            mine  = (m_own == 1) ? ra : rb;
            other = (m_own == 1) ? rb : ra;
            if (!mine)                           nxt = other ? 3 - m_own : 0;
            else if (other && m_ten >= MAX_HOLD) nxt = 3 - m_own;
            else                                 nxt = m_own;
        end
        if (nxt == 0) begin
            m_ten = 0;
        end else if (nxt != m_own) begin
            m_ten = 1;
            m_last_a = (nxt == 1);
        end else if (m_ten < MAX_HOLD) begin
            m_ten++;
        end
        m_own = nxt;
        if (nxt != 0) m_sel = (nxt == 1);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // driver: inputs change on the falling edge, outputs sampled 1 after rising edge
    task automatic step(input bit r, input bit ra, input bit rb,
                        input logic [W-1:0] da, input logic [W-1:0] db);
        @(negedge clk);
        rst = r; req_a = ra; req_b = rb; data_a = da; data_b = db;
        @(posedge clk);
        model_step(r, ra, rb);
        #1;
    endtask

    task automatic chk_model(input string tag);
        logic [W-1:0] exp_y;
        exp_y = m_sel ? data_a : data_b;
        chk({tag, ".gnt_a"}, 32'(gnt_a), 32'(m_own == 1));
        chk({tag, ".gnt_b"}, 32'(gnt_b), 32'(m_own == 2));
        chk({tag, ".sel"},   32'(sel),   32'(m_sel));
        chk({tag, ".valid"}, 32'(valid), 32'(m_own != 0));
        chk({tag, ".y"},     32'(y),     32'(exp_y));
    endtask

    typedef struct {
        bit           r, ra, rb;
        logic [W-1:0] da, db;
        bit           ga, gb, s;
        logic [W-1:0] ey;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs[NV];

    initial begin
        logic [W-1:0] da, db;
        bit exp_a;

        vecs[0]  = '{1, 0, 0, 4'd1,  4'd0, 0, 0, 0, 4'd0};
        vecs[1]  = '{1, 0, 0, 4'd1,  4'd0, 0, 0, 0, 4'd0};
        vecs[2]  = '{0, 1, 0, 4'd1,  4'd0, 1, 0, 1, 4'd1};
        vecs[3]  = '{0, 0, 0, 4'd5,  4'd9, 0, 0, 1, 4'd5};
        vecs[4]  = '{1, 0, 0, 4'd5,  4'd9, 0, 0, 0, 4'd9};
        vecs[5]  = '{0, 1, 1, 4'd3,  4'd6, 1, 0, 1, 4'd3};
        vecs[6]  = '{0, 0, 1, 4'd3,  4'd6, 0, 1, 0, 4'd6};
        vecs[7]  = '{0, 0, 0, 4'd3,  4'd6, 0, 0, 0, 4'd6};
        vecs[8]  = '{0, 1, 1, 4'd3,  4'd6, 1, 0, 1, 4'd3};
        vecs[9]  = '{0, 1, 1, 4'd3,  4'd6, 1, 0, 1, 4'd3};
        vecs[10] = '{0, 1, 1, 4'd3,  4'd6, 1, 0, 1, 4'd3};
        vecs[11] = '{0, 1, 1, 4'd3,  4'd6, 1, 0, 1, 4'd3};
        vecs[12] = '{0, 1, 1, 4'd3,  4'd6, 0, 1, 0, 4'd6};
        vecs[13] = '{0, 1, 1, 4'd3,  4'd6, 0, 1, 0, 4'd6};
        vecs[14] = '{0, 1, 1, 4'd3,  4'd6, 0, 1, 0, 4'd6};
        vecs[15] = '{1, 1, 1, 4'd3,  4'd6, 0, 0, 0, 4'd6};
        vecs[16] = '{0, 1, 1, 4'd3,  4'd6, 1, 0, 1, 4'd3};
        vecs[17] = '{0, 1, 0, 4'd10, 4'd5, 1, 0, 1, 4'd10};

        for (int i = 0; i < NV; i++) begin
            step(vecs[i].r, vecs[i].ra, vecs[i].rb, vecs[i].da, vecs[i].db);
            chk($sformatf("vec%0d.gnt_a", i), 32'(gnt_a), 32'(vecs[i].ga));
            chk($sformatf("vec%0d.gnt_b", i), 32'(gnt_b), 32'(vecs[i].gb));
            chk($sformatf("vec%0d.sel", i),   32'(sel),   32'(vecs[i].s));
            chk($sformatf("vec%0d.valid", i), 32'(valid), 32'(vecs[i].ga | vecs[i].gb));
            chk($sformatf("vec%0d.y", i),     32'(y),     32'(vecs[i].ey));
        end

        // hold timeout: both requesting, tenures alternate every MAX_HOLD cycles
        step(1, 0, 0, '0, '0);
        for (int k = 1; k <= 20; k++) begin
            da = W'($urandom_range(0, 15));
            db = W'($urandom_range(0, 15));
            step(0, 1, 1, da, db);
            exp_a = (((k - 1) / MAX_HOLD) % 2) == 0;
            chk($sformatf("hold%0d.gnt_a", k), 32'(gnt_a), 32'(exp_a));
            chk($sformatf("hold%0d.gnt_b", k), 32'(gnt_b), 32'(!exp_a));
            chk($sformatf("hold%0d.onehot", k), 32'(gnt_a & gnt_b), 32'd0);
            chk($sformatf("hold%0d.y", k), 32'(y), 32'(exp_a ? da : db));
        end

        // lone requester keeps the lane indefinitely
        step(1, 0, 0, '0, '0);
        for (int k = 1; k <= 50; k++) begin
            da = W'($urandom_range(0, 15));
            db = W'($urandom_range(0, 15));
            step(0, 0, 1, da, db);
            chk($sformatf("lone%0d.gnt_b", k), 32'(gnt_b), 32'd1);
            chk($sformatf("lone%0d.y", k), 32'(y), 32'(db));
        end

        // reset mid-tenure inside GNT_B, then both request: A first
        step(1, 0, 0, '0, '0);
        step(0, 0, 1, 4'd2, 4'd7);
        step(0, 1, 1, 4'd2, 4'd7);
        step(0, 1, 1, 4'd2, 4'd7);
        step(1, 1, 1, 4'd2, 4'd7);
        chk("midrst.gnt_b", 32'(gnt_b), 32'd0);
        chk("midrst.sel",   32'(sel),   32'd0);
        chk("midrst.valid", 32'(valid), 32'd0);
        step(0, 1, 1, 4'd2, 4'd7);
        chk("midrst.first_a", 32'(gnt_a), 32'd1);
        chk("midrst.y",       32'(y),     32'd2);

        // randomized traffic with sticky request levels and rare resets
        step(1, 0, 0, '0, '0);
        chk_model("rnd_reset");
        begin
            bit ra, rb, r;
            ra = 0; rb = 0;
            for (int k = 0; k < 600; k++) begin
                if ($urandom_range(0, 3) == 0) ra = ~ra;
                if ($urandom_range(0, 3) == 0) rb = ~rb;
                r = ($urandom_range(0, 63) == 0);
                step(r, ra, rb, W'($urandom_range(0, 15)), W'($urandom_range(0, 15)));
                chk_model($sformatf("rnd%0d", k));
                chk($sformatf("rnd%0d.onehot", k), 32'(gnt_a & gnt_b), 32'd0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mux2_rr_arbiter.md
# mux2_rr_arbiter

Round-robin arbiter and sequencer for the shared 2:1 select datapath. Two requesters, A and B, compete for one output lane. The block registers the select (`sel = 1` routes A, `sel = 0` routes B) and issues one-hot grants. It bounds each tenure with a hold timer so neither requester can starve the other. It sits between the requester logic and the `uo_out` pin driver.

## Interface
Parameters:
- `W`, default 1: data width per requester.
- `MAX_HOLD`, default 8, legal range 2..255: maximum consecutive granted cycles while the other side is requesting.

Ports:
- `clk`, input, 1: the single clock; all state updates on its rising edge.
- `rst`, input, 1: reset, synchronous and active-high.
- `req_a`, input, 1: requester A wants the lane; level, held for the whole transfer.
- `req_b`, input, 1: requester B wants the lane; level.
- `data_a`, input, W: A payload.
- `data_b`, input, W: B payload.
- `gnt_a`, output, 1: registered grant to A.
- `gnt_b`, output, 1: registered grant to B.
- `sel`, output, 1: registered mux select; 1 selects A, 0 selects B.
- `y`, output, W: combinational `sel ? data_a : data_b`.
- `valid`, output, 1: `gnt_a | gnt_b`; `y` is meaningful only while this is high.

## Operation
- Three states:
  - IDLE: `gnt_a = gnt_b = 0`; `sel` holds its last value.
  - GNT_A: `gnt_a = 1`, `sel = 1`.
  - GNT_B: `gnt_b = 1`, `sel = 0`.
- `last` register records the last granted side. Reset value is B, so A wins the first tie.
- IDLE transitions:
  - Only `req_a` → GNT_A.
  - Only `req_b` → GNT_B.
  - Both → the side that is not `last`.
  - Neither → stay in IDLE.
- GNT_A transitions (GNT_B is mirror-symmetric):
  - `req_a = 0` and `req_b = 1` → GNT_B directly, with no idle bubble.
  - `req_a = 0` and `req_b = 0` → IDLE.
  - `req_a = 1`, `req_b = 1`, and `hold_cnt == MAX_HOLD-1` → forced switch to GNT_B.
  - Otherwise stay.
- `hold_cnt` (8 bits):
  - Clears on every state change, and in IDLE.
  - Increments each cycle the state is unchanged.
  - Saturates at `MAX_HOLD-1`.
  - A lone requester keeps the grant indefinitely. The timer only forces a switch while the other side is requesting.
- `last` updates on every entry into GNT_A or GNT_B.
- Grants are one-hot or zero. `gnt_a & gnt_b` is never 1.

## Timing
- Reset values: state IDLE, `gnt_a = 0`, `gnt_b = 0`, `sel = 0`, `valid = 0`, `hold_cnt = 0`, `last` = B. `y` is then `data_b`, combinationally.
- Latency: a request sampled high at edge n gives its grant visible after edge n. That is one cycle of request-to-grant latency.
- A requester that deasserts `req` is released at the next edge. Its grant falls one cycle after the `req` drop. One trailing cycle of grant with `req` low is legal; requesters must ignore it.
- `y` follows `data_*` in the same cycle and carries no register stage.
- Forced switch: with both requesting continuously, each tenure lasts exactly `MAX_HOLD` cycles.
- `rst` asserted mid-tenure: grants drop at the next edge and all state returns to its reset values. There is no partial tenure carry-over.
- Simultaneous release and other-side request is served as a direct handover (A→B); IDLE is never visited.

## Structure
- Shared package `mux2_arb_pkg`:
  - state enum `{IDLE, GNT_A, GNT_B}`;
  - constants `SEL_A = 1'b1` and `SEL_B = 1'b0`;
  - `HOLD_W = 8`.
- One natural sub-module: `mux2_hold_timer`.
  - Inputs: `clk`, `rst`, `clear`, `en`.
  - Output: `expired` (`cnt == MAX_HOLD-1`).
  - Behaviour: saturating counter, parameter `MAX_HOLD`.
- Top level holds the FSM, the `last` register, the registered `sel` and grants, and the output mux.

## Test plan
- **Reset, then single request.** Assert `rst` for 2 cycles, then `req_a = 1`, `data_a = 1`, `data_b = 0` → `gnt_a` = 1 one cycle later, `sel` = 1, `y` = 1, `valid` = 1. Before that, all outputs are 0.
- **First tie, then round-robin.** From reset, `req_a` and `req_b` both rise in the same cycle → A is granted first. Drop `req_a` → `gnt_b` rises on the next edge with no IDLE cycle. Drop `req_b`, then raise both again → A is granted (since `last` = B).
- **Hold timeout.** `MAX_HOLD` = 4, both requests held high for 20 cycles → grants alternate A,A,A,A,B,B,B,B,… and `gnt_a & gnt_b` is never 1.
- **Lone requester.** `req_b` high for 50 cycles with `req_a` low → `gnt_b` stays high for all 49 cycles after the first grant, with no forced release.
- **Reset mid-tenure.** During GNT_B at `hold_cnt` = 2, pulse `rst` for 1 cycle → next cycle shows `gnt_b` = 0, `sel` = 0, `valid` = 0. With both requests still high afterwards, A is granted first.
- **Data routing.** With `W` = 4, sweep `data_a` and `data_b` with distinct values under each grant → `y` equals the granted side's data in the same cycle, every cycle.
